// File: rtl/dmux_pkg.sv
// rtl/dmux_pkg.sv - shared constants, state encoding and round-robin picker for the dispatch controller
package dmux_pkg;

    localparam int N_OUT = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Returns {found, idx}. The search starts at ptr+1 and wraps, so ptr itself
    // has the lowest priority and is only chosen when it is the sole requester.
    // Iterating from farthest to nearest lets the nearest set bit overwrite.
    function automatic logic [SEL_W:0] rr_pick(input logic [SEL_W-1:0] ptr,
                                               input logic [N_OUT-1:0] req);
        logic [SEL_W:0]   res;
        logic [SEL_W-1:0] idx;
        res = '0;
        for (int i = N_OUT; i >= 1; i--) begin
            idx = ptr + SEL_W'(i);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmux_dispatch_ctrl_if.sv
// rtl/dmux_dispatch_ctrl_if.sv - source/sink bundle between bit source, dispatch controller and destinations
// Signals:
//   in_valid/in_ready/in_data : 1-bit item handshake from the source
//   mode/fixed_sel            : routing policy, sampled at the handshake
//   dst_ready                 : per-destination ready
//   y/y_valid/cur_sel         : routed bit, one-hot strobe, applied select
//   busy/drop                 : controller status, timeout discard pulse
// Modports: slave = controller side, master = source/sink side.
interface dmux_dispatch_ctrl_if;
    import dmux_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic             in_data;
    logic             mode;
    logic [SEL_W-1:0] fixed_sel;
    logic [N_OUT-1:0] dst_ready;
    logic [N_OUT-1:0] y;
    logic [N_OUT-1:0] y_valid;
    logic [SEL_W-1:0] cur_sel;
    logic             busy;
    logic             drop;

    modport slave (
        input  in_valid, in_data, mode, fixed_sel, dst_ready,
        output in_ready, y, y_valid, cur_sel, busy, drop
    );

    modport master (
        output in_valid, in_data, mode, fixed_sel, dst_ready,
        input  in_ready, y, y_valid, cur_sel, busy, drop
    );

endinterface

// File: rtl/demux_bf.sv
// rtl/demux_bf.sv - combinational 1:8 bit demultiplexer
// Ports: a = data bit, s = select, y = one-hot placement of a (y[s]=a, others 0).
module demux_bf
    import dmux_pkg::*;
(
    input  logic             a,
    input  logic [SEL_W-1:0] s,
    output logic [N_OUT-1:0] y
);

    always_comb begin
        y    = '0;
        y[s] = a;
    end

endmodule

// File: rtl/dmux_dispatch_ctrl.sv
// rtl/dmux_dispatch_ctrl.sv - sequencing controller feeding demux_bf with RR/fixed routing and stall timeout
// Ports: clk, rst (async, active-high), bus (dmux_dispatch_ctrl_if.slave).
// Parameters: HOLD_CYC = DRIVE length in cycles (1..15), TIMEOUT = ARB cycles
// before an item is dropped (0 = wait forever, at most 255).
module dmux_dispatch_ctrl
    import dmux_pkg::*;
#(
    parameter int HOLD_CYC = 1,
    parameter int TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    dmux_dispatch_ctrl_if.slave   bus
);

    state_t           state_q, state_d;
    logic             data_q,  data_d;
    logic             mode_q,  mode_d;
    logic [SEL_W-1:0] fsel_q,  fsel_d;
    logic [SEL_W-1:0] sel_q,   sel_d;
    logic [SEL_W-1:0] ptr_q,   ptr_d;
    logic [7:0]       stall_q, stall_d;
    logic [3:0]       hold_q,  hold_d;
    logic [N_OUT-1:0] y_q,     y_d;
    logic             drop_q,  drop_d;

    logic [SEL_W:0]   pick;
    logic             grant;
    logic [SEL_W-1:0] gsel;
    logic [N_OUT-1:0] demux_y;

    assign pick = rr_pick(ptr_q, bus.dst_ready);

    // Fed with the next select so the registered y lines up with y_valid
    // in the first DRIVE cycle rather than one cycle later.
    demux_bf u_demux (
        .a (data_q),
        .s (sel_d),
        .y (demux_y)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        fsel_d  = fsel_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        stall_d = stall_q;
        hold_d  = hold_q;
        drop_d  = 1'b0;
        grant   = 1'b0;
        gsel    = sel_q;

        case (state_q)
            IDLE: begin
                stall_d = '0;
                hold_d  = '0;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    mode_d  = bus.mode;
                    fsel_d  = bus.fixed_sel;
                    state_d = ARB;
                end
            end
            ARB: begin
                if (!mode_q) begin
                    grant = pick[SEL_W];
                    gsel  = pick[SEL_W-1:0];
                end else if (bus.dst_ready[fsel_q]) begin
                    grant = 1'b1;
                    gsel  = fsel_q;
                end
                if (grant) begin
                    sel_d   = gsel;
                    state_d = DRIVE;
                    stall_d = '0;
                    hold_d  = '0;
                end else if ((TIMEOUT != 0) && (int'(stall_q) + 1 >= TIMEOUT)) begin
                    drop_d  = 1'b1;
                    state_d = IDLE;
                    stall_d = '0;
                end else if (stall_q != 8'hFF) begin
                    // Saturates so an unbounded stall never wraps.
                    stall_d = stall_q + 8'd1;
                end
            end
            DRIVE: begin
                if (hold_q == 4'(HOLD_CYC - 1)) begin
                    if (!mode_q) begin
                        ptr_d = sel_q;
                    end
                    hold_d  = '0;
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        y_d = (state_d == DRIVE) ? demux_y : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= 1'b0;
            mode_q  <= 1'b0;
            fsel_q  <= '0;
            sel_q   <= '0;
            ptr_q   <= SEL_W'(N_OUT - 1);
            stall_q <= '0;
            hold_q  <= '0;
            y_q     <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            fsel_q  <= fsel_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            stall_q <= stall_d;
            hold_q  <= hold_d;
            y_q     <= y_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.y        = y_q;
    assign bus.y_valid  = (state_q == DRIVE) ? (N_OUT'(1) << sel_q) : '0;
    assign bus.cur_sel  = sel_q;
    assign bus.drop     = drop_q;

endmodule

// File: tb/tb_dmux_dispatch_ctrl.sv
// tb/tb_dmux_dispatch_ctrl.sv - directed self-checking bench for dmux_dispatch_ctrl
module tb_dmux_dispatch_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    dmux_dispatch_ctrl_if dif ();

    dmux_dispatch_ctrl #(
        .HOLD_CYC (1),
        .TIMEOUT  (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dif.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", dif.in_ready); end
        checks++;
        if (dif.y !== 8'h00) begin errors++; $display("FAIL reset_y: got %h expected 00", dif.y); end
        checks++;
        if (dif.y_valid !== 8'h00) begin errors++; $display("FAIL reset_y_valid: got %h expected 00", dif.y_valid); end
        checks++;
        if (dif.cur_sel !== 3'd0) begin errors++; $display("FAIL reset_cur_sel: got %0d expected 0", dif.cur_sel); end
        checks++;
        if ({dif.busy, dif.drop} !== 2'b00) begin errors++; $display("FAIL reset_busy_drop: got %b expected 00", {dif.busy, dif.drop}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Walks all eight destinations and wraps back to 0, 3 cycles per item.
    task automatic test_rr_walk();
        logic       d;
        logic [7:0] ev;
        logic [7:0] ey;
        dif.mode      = 1'b0;
        dif.dst_ready = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            d  = (i % 2 == 0);
            ev = 8'h01 << (i % 8);
            ey = d ? ev : 8'h00;
            dif.in_valid = 1'b1;
            dif.in_data  = d;
            @(negedge clk);
            dif.in_valid = 1'b0;
            checks++;
            if ({dif.in_ready, dif.busy, dif.y_valid} !== {2'b01, 8'h00}) begin
                errors++; $display("FAIL rr_walk_arb item %0d: got %b expected %b", i, {dif.in_ready, dif.busy, dif.y_valid}, {2'b01, 8'h00});
            end
            @(negedge clk);
            checks++;
            if (dif.y_valid !== ev) begin errors++; $display("FAIL rr_walk_y_valid item %0d: got %h expected %h", i, dif.y_valid, ev); end
            checks++;
            if (dif.y !== ey) begin errors++; $display("FAIL rr_walk_y item %0d: got %h expected %h", i, dif.y, ey); end
            checks++;
            if (dif.cur_sel !== 3'(i % 8)) begin errors++; $display("FAIL rr_walk_cur_sel item %0d: got %0d expected %0d", i, dif.cur_sel, i % 8); end
            @(negedge clk);
            checks++;
            if ({dif.in_ready, dif.y_valid} !== {1'b1, 8'h00}) begin
                errors++; $display("FAIL rr_walk_ready item %0d: got %b expected %b", i, {dif.in_ready, dif.y_valid}, {1'b1, 8'h00});
            end
        end
    endtask

    // ptr=0 after the walk; only 2 and 5 ready, so grants alternate 2,5,2,5.
    task automatic test_rr_sparse();
        logic [7:0] ev;
        dif.dst_ready = 8'b0010_0100;
        for (int i = 0; i < 4; i++) begin
            ev = (i % 2 == 0) ? 8'h04 : 8'h20;
            dif.in_valid = 1'b1;
            dif.in_data  = 1'b1;
            @(negedge clk);
            dif.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (dif.y_valid !== ev) begin errors++; $display("FAIL rr_sparse_grant item %0d: got %h expected %h", i, dif.y_valid, ev); end
            checks++;
            if (dif.y !== ev) begin errors++; $display("FAIL rr_sparse_y item %0d: got %h expected %h", i, dif.y, ev); end
            @(negedge clk);
        end
    endtask

    // ptr=5 and only destination 5 ready: it wins again after a full circle.
    task automatic test_full_circle();
        dif.dst_ready = 8'b0010_0000;
        dif.in_valid  = 1'b1;
        dif.in_data   = 1'b0;
        @(negedge clk);
        dif.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.y_valid !== 8'h20) begin errors++; $display("FAIL full_circle_grant: got %h expected 20", dif.y_valid); end
        checks++;
        if (dif.y !== 8'h00) begin errors++; $display("FAIL full_circle_zero_data: got %h expected 00", dif.y); end
        @(negedge clk);
    endtask

    task automatic test_fixed_stall();
        dif.mode      = 1'b1;
        dif.fixed_sel = 3'd6;
        dif.dst_ready = 8'hBF;
        dif.in_valid  = 1'b1;
        dif.in_data   = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        dif.mode     = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if ({dif.busy, dif.drop, dif.y_valid} !== {2'b10, 8'h00}) begin
                errors++; $display("FAIL fixed_stall cycle %0d: got %b expected %b", c, {dif.busy, dif.drop, dif.y_valid}, {2'b10, 8'h00});
            end
            if (c == 5) dif.dst_ready = 8'hFF;
            else @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (dif.y !== 8'h40) begin errors++; $display("FAIL fixed_y: got %h expected 40", dif.y); end
        checks++;
        if (dif.y_valid !== 8'h40) begin errors++; $display("FAIL fixed_y_valid: got %h expected 40", dif.y_valid); end
        checks++;
        if (dif.drop !== 1'b0) begin errors++; $display("FAIL fixed_no_drop: got %b expected 0", dif.drop); end
        @(negedge clk);
    endtask

    // ptr=5 from the full-circle item; after the drop the next RR grant is 6.
    task automatic test_timeout();
        int cyc;
        int extra;
        dif.mode      = 1'b0;
        dif.dst_ready = 8'h00;
        dif.in_valid  = 1'b1;
        dif.in_data   = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        cyc = 1;
        while (dif.drop !== 1'b1 && cyc < 40) begin
            checks++;
            if (dif.busy !== 1'b1) begin errors++; $display("FAIL timeout_busy cycle %0d: got %b expected 1", cyc, dif.busy); end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== 16) begin errors++; $display("FAIL timeout_drop_cycle: got %0d expected 16", cyc); end
        checks++;
        if ({dif.in_ready, dif.busy} !== 2'b10) begin errors++; $display("FAIL timeout_idle: got %b expected 10", {dif.in_ready, dif.busy}); end
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (dif.drop === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL timeout_single_pulse: got %0d extra expected 0", extra); end
        dif.dst_ready = 8'hFF;
        dif.in_valid  = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.y_valid !== 8'h40) begin errors++; $display("FAIL timeout_ptr_kept: got %h expected 40", dif.y_valid); end
        @(negedge clk);
    endtask

    // RR from ptr=6 would pick 7; the captured fixed select 3 must win.
    task automatic test_mode_capture();
        dif.mode      = 1'b1;
        dif.fixed_sel = 3'd3;
        dif.dst_ready = 8'h00;
        dif.in_valid  = 1'b1;
        dif.in_data   = 1'b1;
        @(negedge clk);
        dif.in_valid  = 1'b0;
        dif.mode      = 1'b0;
        dif.fixed_sel = 3'd7;
        @(negedge clk);
        dif.dst_ready = 8'hFF;
        @(negedge clk);
        checks++;
        if (dif.y_valid !== 8'h08) begin errors++; $display("FAIL mode_capture_grant: got %h expected 08", dif.y_valid); end
        checks++;
        if (dif.cur_sel !== 3'd3) begin errors++; $display("FAIL mode_capture_cur_sel: got %0d expected 3", dif.cur_sel); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_drive();
        dif.mode      = 1'b1;
        dif.fixed_sel = 3'd3;
        dif.dst_ready = 8'hFF;
        dif.in_valid  = 1'b1;
        dif.in_data   = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        dif.mode     = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.y !== 8'h08) begin errors++; $display("FAIL mid_drive_setup_y: got %h expected 08", dif.y); end
        rst = 1'b1;
        #1;
        checks++;
        if ({dif.y, dif.y_valid} !== 16'h0000) begin errors++; $display("FAIL async_reset_outputs: got %h expected 0000", {dif.y, dif.y_valid}); end
        checks++;
        if ({dif.busy, dif.drop, dif.in_ready} !== 3'b001) begin errors++; $display("FAIL async_reset_status: got %b expected 001", {dif.busy, dif.drop, dif.in_ready}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        dif.in_valid = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.y_valid !== 8'h01) begin errors++; $display("FAIL post_reset_first_grant: got %h expected 01", dif.y_valid); end
        @(negedge clk);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.in_data   = 1'b0;
        dif.mode      = 1'b0;
        dif.fixed_sel = 3'd0;
        dif.dst_ready = 8'h00;
        test_reset();
        test_rr_walk();
        test_rr_sparse();
        test_full_circle();
        test_fixed_stall();
        test_timeout();
        test_mode_capture();
        test_reset_mid_drive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
